// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - shared constants and round-robin pick helper for register-file arbiters
//
// Purpose: register-file geometry constants and rr_pick, a rotate / find-first /
// un-rotate search usable by any arbiter of up to MAX_REQ requesters.
// Ports: none (package).
package rf_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int MAX_REQ    = 8;

  // Returns {found, index}. The search begins at ptr and walks upward modulo n.
  // Walking the rotated vector from the top down lets the lowest rotated
  // position, i.e. the one closest to ptr, be written last and win.
  function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0]         ptr,
                                         input int                 n);
    logic [MAX_REQ-1:0] rot;
    logic [3:0]         res;
    int                 idx;
    res = '0;
    rot = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = (int'(ptr) + i) % n;
      if (i < n) rot[i] = valid[idx];
    end
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (rot[i]) res = {1'b1, 3'((int'(ptr) + i) % n)};
    end
    return res;
  endfunction

endpackage

// File: rtl/mux32.sv
// rtl/mux32.sv - shared 32-way register-file read multiplexer
//
// Purpose: combinational 32:1 select of N-bit words.
// Ports:
//   d_flat  in  32*N  word k occupies bits [k*N +: N]
//   s       in  5     select
//   out     out N     selected word
module mux32 #(
  parameter int N = 32
) (
  input  logic [32*N-1:0] d_flat,
  input  logic [4:0]      s,
  output logic [N-1:0]    out
);

  assign out = d_flat[int'(s)*N +: N];

endmodule

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin one-hot pick
//
// Purpose: picks the first asserted request at or above ptr_i, wrapping.
// Ports:
//   req_valid_i  in  NUM_REQ  pending requests
//   ptr_i        in  ID_W     highest-priority requester index
//   pick_o       out NUM_REQ  one-hot (or zero) winner
//   pick_id_o    out ID_W     winner index (valid when pick_vld_o)
//   pick_vld_o   out 1        any request pending
module rr_priority_pick
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic [ID_W-1:0]    pick_id_o,
  output logic               pick_vld_o
);

  logic [3:0] res;

  always_comb begin
    res        = rr_pick(MAX_REQ'(req_valid_i), 3'(ptr_i), NUM_REQ);
    pick_vld_o = res[3];
    pick_id_o  = ID_W'(res[2:0]);
    pick_o     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (res[3] && int'(res[2:0]) == i) pick_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/rf_read_arbiter.sv
// rtl/rf_read_arbiter.sv - round-robin arbiter sharing one register-file read port
//
// Purpose: grants one requester per cycle, drives the shared mux select from the
// winner's address (S1), captures the mux output a cycle later (S2) and returns
// it with the winner's ID on a valid/ready channel.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   req_valid    in  NUM_REQ    per-requester read request
//   req_addr     in  NUM_REQ*5  requester i address at [5i+4:5i]
//   req_ready    out NUM_REQ    one-hot-or-zero grant
//   mux_sel      out 5          shared mux select (= sel_q)
//   mux_out      in  N          shared mux output
//   rsp_valid    out 1          response valid
//   rsp_ready    in  1          response consumer ready
//   rsp_data     out N          captured read data
//   rsp_id       out ID_W       owner of rsp_data
module rf_read_arbiter
  import rf_arb_pkg::*;
#(
  parameter  int N       = 32,
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [REG_ADDR_W-1:0]         mux_sel,
  input  logic [N-1:0]                  mux_out,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [N-1:0]                  rsp_data,
  output logic [ID_W-1:0]               rsp_id
);

  logic                  s1_v_q, s1_v_d;
  logic [REG_ADDR_W-1:0] sel_q, sel_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [N-1:0]          rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]       rsp_id_q, rsp_id_d;

  logic                  s2_free, s1_free, grant;
  logic [NUM_REQ-1:0]    pick;
  logic [ID_W-1:0]       pick_id;
  logic                  pick_vld;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_valid_i (req_valid),
    .ptr_i       (ptr_q),
    .pick_o      (pick),
    .pick_id_o   (pick_id),
    .pick_vld_o  (pick_vld)
  );

  always_comb begin
    s2_free = !rsp_valid_q || rsp_ready;
    s1_free = !s1_v_q || s2_free;
    // rst gates the grant so no requester sees a handshake during reset.
    grant     = s1_free && pick_vld && !rst;
    req_ready = grant ? pick : '0;

    s1_v_d      = s1_v_q;
    sel_d       = sel_q;
    id_d        = id_q;
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;

    if (grant) begin
      sel_d  = req_addr[int'(pick_id)*REG_ADDR_W +: REG_ADDR_W];
      id_d   = pick_id;
      s1_v_d = 1'b1;
      ptr_d  = (int'(pick_id) == NUM_REQ - 1) ? '0 : pick_id + ID_W'(1);
    end else if (s1_free) begin
      // sel_q deliberately holds so the shared mux does not toggle.
      s1_v_d = 1'b0;
    end

    if (s1_v_q && s2_free) begin
      rsp_data_d  = mux_out;
      rsp_id_d    = id_q;
      rsp_valid_d = 1'b1;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q      <= 1'b0;
      sel_q       <= '0;
      id_q        <= '0;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      s1_v_q      <= s1_v_d;
      sel_q       <= sel_d;
      id_q        <= id_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign mux_sel   = sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_rf_read_arbiter.sv
// tb/tb_rf_read_arbiter.sv - scoreboard bench for rf_read_arbiter
module tb_rf_read_arbiter;

  localparam int N        = 32;
  localparam int NUM_REQ  = 4;
  localparam int ID_W     = 2;
  localparam logic [N-1:0] REG0_VAL  = 32'h0BAD_F00D;
  localparam logic [N-1:0] REG7_VAL  = 32'hDEAD_BEEF;
  localparam logic [N-1:0] REG31_VAL = 32'hCAFE_F00D;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*5-1:0]   req_addr;
  logic [NUM_REQ-1:0]     req_ready;
  logic [4:0]             mux_sel;
  logic [N-1:0]           mux_out;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [N-1:0]           rsp_data;
  logic [ID_W-1:0]        rsp_id;

  logic [N-1:0]           regs [32];
  logic [32*N-1:0]        reg_flat;

  always #5 clk = ~clk;

  always_comb begin
    reg_flat = '0;
    for (int i = 0; i < 32; i++) reg_flat[i*N +: N] = regs[i];
  end

  mux32 #(.N(N)) u_mux (
    .d_flat (reg_flat),
    .s      (mux_sel),
    .out    (mux_out)
  );

  rf_read_arbiter #(.N(N), .NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .mux_sel   (mux_sel),
    .mux_out   (mux_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [N-1:0]    data;
  } rsp_t;

  rsp_t               exp_q [$];
  int                 errors = 0;
  int                 checks = 0;
  int                 model_ptr = 0;
  bit                 m_s1 = 1'b0;
  bit                 m_s2 = 1'b0;
  logic [NUM_REQ-1:0] last_grant = '0;
  bit                 last_rsp = 1'b0;
  int                 waits [NUM_REQ];
  int                 n_grants = 0;
  int                 n_rsps = 0;

  function automatic logic [NUM_REQ-1:0] model_pick(logic [NUM_REQ-1:0] v, int p);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[(p + k) % NUM_REQ]) return NUM_REQ'(1 << ((p + k) % NUM_REQ));
    end
    return '0;
  endfunction

  // One clock: sample at negedge, score against the reference pipeline model,
  // then release after the rising edge so the caller can drive new inputs.
  task automatic tick();
    logic [NUM_REQ-1:0] exp_rdy;
    rsp_t               e;
    bit                 s2f, s1f;
    int                 g;
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      m_s1 = 1'b0;
      m_s2 = 1'b0;
      model_ptr = 0;
      for (int i = 0; i < NUM_REQ; i++) waits[i] = 0;
    end
    s2f = !m_s2 || rsp_ready;
    s1f = !m_s1 || s2f;
    exp_rdy = (!rst && s1f) ? model_pick(req_valid, model_ptr) : '0;
    checks++;
    if (req_ready !== exp_rdy) begin
      errors++;
      $display("FAIL req_ready: got %b expected %b at %0t", req_ready, exp_rdy, $time);
    end
    checks++;
    if (rsp_valid !== m_s2) begin
      errors++;
      $display("FAIL rsp_valid: got %b expected %b at %0t", rsp_valid, m_s2, $time);
    end
    last_rsp = 1'b0;
    if (!rst && rsp_valid && rsp_ready) begin
      last_rsp = 1'b1;
      n_rsps++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: got id=%0d data=%h expected none", rsp_id, rsp_data);
      end else begin
        e = exp_q.pop_front();
        if (rsp_data !== e.data || rsp_id !== e.id) begin
          errors++;
          $display("FAIL rsp_payload: got id=%0d data=%h expected id=%0d data=%h",
                   rsp_id, rsp_data, e.id, e.data);
        end
      end
    end
    last_grant = exp_rdy & req_valid;
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (last_grant[i] || !req_valid[i]) waits[i] = 0;
        else if (last_grant != '0) begin
          waits[i]++;
          checks++;
          if (waits[i] > NUM_REQ - 1) begin
            errors++;
            $display("FAIL starvation: req%0d waited %0d grants, limit %0d", i, waits[i], NUM_REQ - 1);
          end
        end
      end
      g = -1;
      for (int i = 0; i < NUM_REQ; i++) if (last_grant[i]) g = i;
      if (g >= 0) begin
        e.id   = ID_W'(g);
        e.data = regs[req_addr[g*5 +: 5]];
        exp_q.push_back(e);
        n_grants++;
        model_ptr = (g + 1) % NUM_REQ;
      end
      m_s2 = (m_s1 && s2f) ? 1'b1 : (rsp_ready ? 1'b0 : m_s2);
      m_s1 = (g >= 0) ? 1'b1 : (s1f ? 1'b0 : m_s1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    req_addr = {5'd3, 5'd2, 5'd1, 5'd0};
    rsp_ready = 1'b0;
    repeat (2) tick();
    checks++;
    if (mux_sel !== 5'd0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: mux_sel=%0d rsp_valid=%b expected 0 0", mux_sel, rsp_valid);
    end
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || mux_sel !== 5'd0 || req_ready !== '0) begin
      errors++;
      $display("FAIL midstream_reset: rsp_valid=%b mux_sel=%0d req_ready=%b expected 0 0 0",
               rsp_valid, mux_sel, req_ready);
    end
    tick();
    rst = 1'b0;
    req_valid = 4'b0100;
    req_addr[14:10] = 5'd7;
    tick();
    checks++;
    if (last_grant !== 4'b0100) begin
      errors++;
      $display("FAIL single_grant: got %b expected 0100", last_grant);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: rsp_valid=%b expected 0", rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== REG7_VAL || rsp_id !== 2'd2) begin
      errors++;
      $display("FAIL single_rsp: valid=%b data=%h id=%0d expected 1 %h 2",
               rsp_valid, rsp_data, rsp_id, REG7_VAL);
    end
    tick();
  endtask

  task automatic test_round_robin();
    reset_pulse();
    req_addr = {5'd13, 5'd12, 5'd11, 5'd10};
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      checks++;
      if (last_grant !== NUM_REQ'(1 << (k % NUM_REQ))) begin
        errors++;
        $display("FAIL rr_order[%0d]: got %b expected %b", k, last_grant, NUM_REQ'(1 << (k % NUM_REQ)));
      end
      if (k >= 2) begin
        checks++;
        if (!last_rsp) begin
          errors++;
          $display("FAIL rr_throughput[%0d]: got no response expected one", k);
        end
      end
    end
    req_valid = '0;
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rr_drain: %0d responses outstanding expected 0", exp_q.size());
    end
  endtask

  task automatic test_wrap();
    reset_pulse();
    rsp_ready = 1'b1;
    req_addr = {5'd4, 5'd5, 5'd6, 5'd8};
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b1001;
    tick();
    checks++;
    if (last_grant !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_first: got %b expected 1000", last_grant);
    end
    req_valid = 4'b0001;
    tick();
    checks++;
    if (last_grant !== 4'b0001) begin
      errors++;
      $display("FAIL wrap_second: got %b expected 0001", last_grant);
    end
    req_valid = 4'b1111;
    tick();
    checks++;
    if (last_grant !== 4'b0010) begin
      errors++;
      $display("FAIL wrap_ptr: got %b expected 0010", last_grant);
    end
    req_valid = '0;
    repeat (3) tick();
  endtask

  task automatic test_backpressure();
    logic [N-1:0] hold_data;
    reset_pulse();
    rsp_ready = 1'b0;
    req_addr = {5'd20, 5'd21, 5'd22, 5'd23};
    req_valid = 4'b0011;
    tick();
    req_valid = 4'b0010;
    tick();
    checks++;
    if (last_grant !== 4'b0010) begin
      errors++;
      $display("FAIL bp_fill: got %b expected 0010", last_grant);
    end
    req_valid = 4'b1100;
    hold_data = rsp_data;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (last_grant !== '0 || rsp_valid !== 1'b1 || rsp_data !== hold_data ||
          rsp_id !== 2'd0 || mux_sel !== 5'd22) begin
        errors++;
        $display("FAIL bp_hold[%0d]: grant=%b valid=%b data=%h id=%0d sel=%0d expected 0000 1 %h 0 22",
                 k, last_grant, rsp_valid, rsp_data, rsp_id, mux_sel, hold_data);
      end
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (last_rsp !== (k < 2)) begin
        errors++;
        $display("FAIL bp_release[%0d]: response=%b expected %b", k, last_rsp, k < 2);
      end
    end
  endtask

  task automatic test_addr_edges();
    reset_pulse();
    rsp_ready = 1'b1;
    req_addr = {5'd0, 5'd0, 5'd31, 5'd0};
    req_valid = 4'b0011;
    tick();
    checks++;
    if (last_grant !== 4'b0001 || mux_sel !== 5'd0) begin
      errors++;
      $display("FAIL edge_addr0: grant=%b sel=%0d expected 0001 0", last_grant, mux_sel);
    end
    req_valid = 4'b0010;
    tick();
    checks++;
    if (last_grant !== 4'b0010 || mux_sel !== 5'd31 || rsp_data !== REG0_VAL || rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL edge_addr31: grant=%b sel=%0d data=%h id=%0d expected 0010 31 %h 0",
               last_grant, mux_sel, rsp_data, rsp_id, REG0_VAL);
    end
    req_valid = '0;
    tick();
    checks++;
    if (rsp_data !== REG31_VAL || rsp_id !== 2'd1) begin
      errors++;
      $display("FAIL edge_rsp31: data=%h id=%0d expected %h 1", rsp_data, rsp_id, REG31_VAL);
    end
    repeat (2) tick();
  endtask

  task automatic test_random();
    reset_pulse();
    n_grants = 0;
    n_rsps = 0;
    rsp_ready = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (last_grant[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 2) == 0);
          req_addr[i*5 +: 5] = 5'($urandom_range(0, 31));
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) tick();
    checks++;
    if (exp_q.size() != 0 || n_grants != n_rsps) begin
      errors++;
      $display("FAIL random_drain: outstanding=%0d grants=%0d responses=%0d expected 0 and equal",
               exp_q.size(), n_grants, n_rsps);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom();
    regs[0]  = REG0_VAL;
    regs[7]  = REG7_VAL;
    regs[31] = REG31_VAL;
    for (int i = 0; i < NUM_REQ; i++) waits[i] = 0;
    rst = 1'b1;
    req_valid = '0;
    req_addr = '0;
    rsp_ready = 1'b0;

    test_reset();
    test_round_robin();
    test_wrap();
    test_backpressure();
    test_addr_edges();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_read_arbiter.md
# rf_read_arbiter

Round-robin arbiter that shares one 32-entry read port (a `mux32`-based register-file read mux) between `NUM_REQ` requesters. It drives the mux select from the granted request's register address and captures the mux output one cycle later. It returns the data with the winner's ID over a valid/ready response channel. Sits between the register file and its clients (decode read ports, debug/CSR readback), with a throughput of one read per cycle.

## Interface
- `N`, 32: data width; must match the shared `mux32` `N`.
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ID_W`, `$clog2(NUM_REQ)`: requester ID width (derived; not overridden).

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester read request.
- `req_addr`  in  NUM_REQ*5  packed register addresses; requester i uses bits [5i+4:5i].
- `req_ready`  out  NUM_REQ  one-hot-or-zero grant (combinational).
- `mux_sel`  out  5  drives the shared `mux32` `s`.
- `mux_out`  in  N  shared `mux32` `out`.
- `rsp_valid`  out  1  response data valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_data`  out  N  captured read data.
- `rsp_id`  out  ID_W  requester index that owns `rsp_data`.

## Operation
- Two-stage pipeline:
  - **S1 (select):** `s1_v`, `sel_q`, `id_q`.
  - **S2 (response):** `rsp_valid`, `rsp_data`, `rsp_id`.
- `mux_sel = sel_q` at all times. The mux is combinational, so `mux_out` is valid in the cycle after the grant.
- `s2_free = !rsp_valid || rsp_ready`.
- `s1_free = !s1_v || s2_free`.
- Grants are issued only when `s1_free`.
- Round-robin arbitration:
  - Priority pointer `ptr` (ID_W bits).
  - Search starts at `ptr` and proceeds upward, wrapping modulo NUM_REQ.
  - The first asserted `req_valid` wins; at most one `req_ready` bit is high.
  - `req_ready` is 0 for all requesters when `!s1_free`.
- Handshake on grant to requester g (`req_valid[g] && req_ready[g]`):
  - `sel_q <= req_addr[g]`, `id_q <= g`, `s1_v <= 1`.
  - `ptr <= (g+1) mod NUM_REQ`. Wrap from NUM_REQ-1 goes to 0.
- No grant while `s1_free`: `s1_v <= 0`. `sel_q` holds its value to avoid needless mux toggling.
- S1→S2 transfer when `s1_v && s2_free`:
  - `rsp_data <= mux_out`, `rsp_id <= id_q`, `rsp_valid <= 1`.
- `rsp_valid` drops only on `rsp_ready && !(s1_v)` at the edge. If S1 is valid at that edge, it refills in the same cycle.
- Back-pressure:
  - When `rsp_valid && !rsp_ready`, S2 holds; `rsp_data` and `rsp_id` are stable.
  - S1 holds with `sel_q` unchanged, so `mux_out` stays valid.
  - No grants are issued.
- Requesters must hold `req_valid` and `req_addr` until granted. Dropping an ungranted request is legal; it simply loses arbitration.
- Address 0 is passed through unchanged. Zeroing x0 is the register file's responsibility.

## Timing
- Reset values (async assert, sync-release expected upstream):
  - `s1_v=0`, `sel_q=0`, `id_q=0`, `ptr=0`.
  - `rsp_valid=0`, `rsp_data=0`, `rsp_id=0`.
  - Consequently `mux_sel=0` and `req_ready=0` while `rst` is high.
- Latency: grant at edge E → `rsp_valid=1` after edge E+1, with data = register[addr] as seen during cycle E..E+1.
- Throughput: one grant per cycle with `rsp_ready` held high.
- Reset mid-operation: in-flight S1/S2 contents are discarded and no response is produced. After release, `ptr=0`.
- Simultaneous events:
  - Grant + S1→S2 + S2 consume can all occur on the same edge.
  - A new grant overwrites `sel_q` only when S1 is advancing or empty.
- Combinational paths: `req_valid`/`rsp_ready` → `req_ready` exist. The path `mux_out` → any output is registered.

## Structure
- `rf_arb_pkg` contains `localparam REG_ADDR_W = 5`, `NUM_REGS = 32`, and the `rr_pick` function (rotate, find-first, un-rotate) used by this block and future arbiters.
- One sub-module: `rr_priority_pick #(NUM_REQ)`, a combinational one-hot pick from `req_valid` and `ptr`.
- Bench instantiates a real `mux32 #(.N(N))` fed from a behavioural 32×N register array.

## Test plan
1. Reset with `rst` high mid-stream → `rsp_valid=0`, `req_ready=0`, `mux_sel=0`. After release, a single request from req2 (addr 7, reg7=0xDEADBEEF) → `rsp_valid` two edges later with `rsp_data=0xDEADBEEF`, `rsp_id=2`.
2. All 4 requesters valid continuously, `rsp_ready=1` → grant order 0,1,2,3,0,… and one response per cycle with matching `rsp_id`/data.
3. ptr=3, req_valid=4'b1001 → req3 granted, then req0 (wrap-around); ptr ends at 1.
4. `rsp_ready=0` for 3 cycles with S1 and S2 full → `rsp_data`/`rsp_id`/`mux_sel` stable, `req_ready=0`. Raising `rsp_ready` delivers both queued responses on consecutive cycles.
5. Address 31 from req1 and address 0 from req0 → data = reg31 and reg0 with correct IDs; `mux_sel` observed as 0 then 31.
6. Random `req_valid`/`rsp_ready` for 10k cycles against a scoreboard → every grant yields exactly one in-order response. No requester is starved for more than NUM_REQ-1 grants.
